// File: rtl/scan_pkg.sv
// Shared types and constants for the 16x16 red/green LED matrix scan driver.
package scan_pkg;

  localparam int NUM_ROWS = 16;
  localparam int NUM_COLS = 16;

  typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] pixel_frame_t;

  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_LOAD     = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_LATCH    = 3'd4,
    S_DWELL    = 3'd5
  } scan_state_t;

endpackage : scan_pkg

// File: rtl/scan_tick.sv
// DIV-cycle divider: tick is high in the last cycle of every DIV-cycle window,
// and the window restarts whenever reload is asserted (FSM state change).
module scan_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (reload || tick) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : scan_tick

// File: rtl/led_matrix_scanner.sv
// Row-at-a-time scan driver for the 16x16 red/green LED panel.
// Define SCAN_BLANK_EN to blank the panel (OE_N high) except during row dwell.
module led_matrix_scanner
  import scan_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int DWELL = 1000
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  pixel_frame_t RedPixels,
  input  pixel_frame_t GrnPixels,
  output logic [3:0]   ROW_SEL,
  output logic         SER_RED,
  output logic         SER_GRN,
  output logic         SCLK,
  output logic         LATCH,
  output logic         OE_N,
  output logic         FRAME_START
);

  localparam int DW = $clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL);

  scan_state_t  state_q, state_d;
  logic [3:0]   row_q, row_d;
  logic [3:0]   col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  pixel_frame_t buf_red_q, buf_red_d;
  pixel_frame_t buf_grn_q, buf_grn_d;

  logic [3:0] row_sel_q, row_sel_d;
  logic       ser_red_q, ser_red_d;
  logic       ser_grn_q, ser_grn_d;
  logic       sclk_q, sclk_d;
  logic       latch_q, latch_d;
  logic       oe_n_q, oe_n_d;
  logic       frame_start_q, frame_start_d;

  logic tick;
  logic state_change;
  logic snap;

  assign state_change = (state_d != state_q);

  scan_tick #(.DIV(DIV)) u_tick (
    .clk    (CLK),
    .rst_n  (RST_N),
    .reload (state_change),
    .tick   (tick)
  );

  // Next-state logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    unique case (state_q)
      S_START: begin
        state_d = S_LOAD;
        row_d   = '0;
      end
      S_LOAD: begin
        state_d = S_SHIFT_LO;
        col_d   = 4'hF;
      end
      S_SHIFT_LO: if (tick) state_d = S_SHIFT_HI;
      S_SHIFT_HI: begin
        if (tick) begin
          if (col_q == 4'd0) begin
            state_d = S_LATCH;
          end else begin
            col_d   = col_q - 4'd1;
            state_d = S_SHIFT_LO;
          end
        end
      end
      S_LATCH: begin
        if (tick) begin
          state_d = S_DWELL;
          dwell_d = DW'(1);
        end
      end
      S_DWELL: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = S_LOAD;
          row_d   = row_q + 4'd1;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = S_START;
    endcase
  end

  // Outputs are computed from the state being entered so the registered
  // values line up with the state occupied in the same cycle.
  always_comb begin
    snap          = (state_d == S_LOAD) && (row_d == 4'd0);
    buf_red_d     = snap ? RedPixels : buf_red_q;
    buf_grn_d     = snap ? GrnPixels : buf_grn_q;
    frame_start_d = snap;
    sclk_d        = (state_d == S_SHIFT_HI);
    latch_d       = (state_d == S_LATCH);
    row_sel_d     = row_sel_q;
    ser_red_d     = ser_red_q;
    ser_grn_d     = ser_grn_q;
    if (state_change && state_d == S_LATCH) row_sel_d = row_q;
    // Data only moves on SHIFT_LO entry, giving DIV cycles of setup to SCLK.
    if (state_change && state_d == S_SHIFT_LO) begin
      ser_red_d = buf_red_q[row_d][col_d];
      ser_grn_d = buf_grn_q[row_d][col_d];
    end
`ifdef SCAN_BLANK_EN
    oe_n_d = (state_d != S_DWELL);
`else
    oe_n_d = 1'b0;
`endif
  end

  // NOTE: the frame buffer is reset along with control state so a restart
  // never displays stale pixels before the first snapshot.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_START;
      row_q         <= '0;
      col_q         <= 4'hF;
      dwell_q       <= '0;
      buf_red_q     <= '0;
      buf_grn_q     <= '0;
      row_sel_q     <= '0;
      ser_red_q     <= 1'b0;
      ser_grn_q     <= 1'b0;
      sclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      dwell_q       <= dwell_d;
      buf_red_q     <= buf_red_d;
      buf_grn_q     <= buf_grn_d;
      row_sel_q     <= row_sel_d;
      ser_red_q     <= ser_red_d;
      ser_grn_q     <= ser_grn_d;
      sclk_q        <= sclk_d;
      latch_q       <= latch_d;
      oe_n_q        <= oe_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ROW_SEL     = row_sel_q;
  assign SER_RED     = ser_red_q;
  assign SER_GRN     = ser_grn_q;
  assign SCLK        = sclk_q;
  assign LATCH       = latch_q;
  assign OE_N        = oe_n_q;
  assign FRAME_START = frame_start_q;

endmodule : led_matrix_scanner
